// File: rtl/instr_decoder_if.sv
// Decoder bus: instruction fetch inputs on one side, datapath
// control strobes on the other.
interface instr_decoder_if #(
    parameter int WIDTH           = 8,
    parameter int ALU_INSTR_WIDTH = 4,
    parameter int REG_F_SEL_SIZE  = 4,
    parameter int IN_B_SEL_SIZE   = 2
);
    logic [WIDTH-1:0]           instr;
    logic [WIDTH-1:0]           arg;
    logic                       z_flag;
    logic                       pc_rst;
    logic                       pc_ld;
    logic [ALU_INSTR_WIDTH-1:0] alu_out;
    logic [WIDTH-1:0]           imm;
    logic [IN_B_SEL_SIZE-1:0]   in_b_sel;
    logic [REG_F_SEL_SIZE-1:0]  reg_f_sel;
    logic                       en_reg_f;
    logic [WIDTH-1:0]           d_mem_addr;
    logic                       d_mem_addr_mode;
    logic                       en_d_mem;
    logic                       en_acc;
    logic [1:0]                 jmp_mode;
    logic [WIDTH-1:0]           base_reg_offset;
    logic                       base_reg_ld;
    logic [WIDTH-1:0]           base_reg_data;
    logic                       lr_ld;

    modport master (
        output instr, arg, z_flag,
        input  pc_rst, pc_ld, alu_out, imm, in_b_sel, reg_f_sel,
        input  en_reg_f, d_mem_addr, d_mem_addr_mode, en_d_mem,
        input  en_acc, jmp_mode, base_reg_offset, base_reg_ld,
        input  base_reg_data, lr_ld
    );

    modport slave (
        input  instr, arg, z_flag,
        output pc_rst, pc_ld, alu_out, imm, in_b_sel, reg_f_sel,
        output en_reg_f, d_mem_addr, d_mem_addr_mode, en_d_mem,
        output en_acc, jmp_mode, base_reg_offset, base_reg_ld,
        output base_reg_data, lr_ld
    );
endinterface

// File: rtl/instr_decoder.sv
// Combinational instruction decoder for the single-cycle 8-bit CPU.
// The only state is link_valid, which arms RET after a CALL.
module instr_decoder #(
    parameter int WIDTH           = 8,
    parameter int ALU_INSTR_WIDTH = 4,
    parameter int REG_F_SEL_SIZE  = 4,
    parameter int IN_B_SEL_SIZE   = 2
) (
    input  logic            clk,
    input  logic            rst,
    instr_decoder_if.slave  bus
);
    localparam logic [WIDTH-1:0] OP_RST  = WIDTH'('h01);
    localparam logic [WIDTH-1:0] OP_LD   = WIDTH'('h02);
    localparam logic [WIDTH-1:0] OP_ST   = WIDTH'('h03);
    localparam logic [WIDTH-1:0] OP_LDR  = WIDTH'('h04);
    localparam logic [WIDTH-1:0] OP_STR  = WIDTH'('h05);
    localparam logic [WIDTH-1:0] OP_BAR  = WIDTH'('h06);
    localparam logic [WIDTH-1:0] OP_JMP  = WIDTH'('h07);
    localparam logic [WIDTH-1:0] OP_JMPO = WIDTH'('h08);
    localparam logic [WIDTH-1:0] OP_LDI  = WIDTH'('h09);
    localparam logic [WIDTH-1:0] OP_LDAR = WIDTH'('h0A);
    localparam logic [WIDTH-1:0] OP_XORR = WIDTH'('h0B);
    localparam logic [WIDTH-1:0] OP_ORR  = WIDTH'('h0C);
    localparam logic [WIDTH-1:0] OP_ANDR = WIDTH'('h0D);
    localparam logic [WIDTH-1:0] OP_ADDR = WIDTH'('h0E);
    localparam logic [WIDTH-1:0] OP_SUBR = WIDTH'('h0F);
    localparam logic [WIDTH-1:0] OP_CALL = WIDTH'('h10);
    localparam logic [WIDTH-1:0] OP_RET  = WIDTH'('h11);
    localparam logic [WIDTH-1:0] OP_JZ   = WIDTH'('h12);
    localparam logic [WIDTH-1:0] OP_JNZ  = WIDTH'('h13);
    localparam logic [WIDTH-1:0] OP_STAR = WIDTH'('h14);

    localparam logic [IN_B_SEL_SIZE-1:0] B_IMM  = IN_B_SEL_SIZE'(0);
    localparam logic [IN_B_SEL_SIZE-1:0] B_REG  = IN_B_SEL_SIZE'(1);
    localparam logic [IN_B_SEL_SIZE-1:0] B_DMEM = IN_B_SEL_SIZE'(2);

    logic link_valid;

    // Single-level link: CALL arms it, a taken RET disarms it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_valid <= 1'b0;
        end else if (bus.instr == OP_CALL) begin
            link_valid <= 1'b1;
        end else if (bus.instr == OP_RET) begin
            link_valid <= 1'b0;
        end
    end

    always_comb begin
        bus.pc_rst          = 1'b0;
        bus.pc_ld           = 1'b0;
        bus.alu_out         = '0;
        bus.imm             = bus.arg;
        bus.in_b_sel        = B_IMM;
        bus.reg_f_sel       = bus.arg[REG_F_SEL_SIZE-1:0];
        bus.en_reg_f        = 1'b0;
        bus.d_mem_addr      = bus.arg;
        bus.d_mem_addr_mode = 1'b0;
        bus.en_d_mem        = 1'b0;
        bus.en_acc          = 1'b0;
        bus.jmp_mode        = 2'b00;
        bus.base_reg_offset = bus.arg;
        bus.base_reg_ld     = 1'b0;
        bus.base_reg_data   = bus.arg;
        bus.lr_ld           = 1'b0;
        if (rst) begin
            bus.pc_rst          = 1'b1;
            bus.imm             = '0;
            bus.reg_f_sel       = '0;
            bus.d_mem_addr      = '0;
            bus.base_reg_offset = '0;
            bus.base_reg_data   = '0;
        end else begin
            unique case (bus.instr)
                OP_RST: bus.pc_rst = 1'b1;
                OP_LD, OP_LDR: begin
                    bus.en_acc          = 1'b1;
                    bus.in_b_sel        = B_DMEM;
                    bus.d_mem_addr_mode = (bus.instr == OP_LDR);
                end
                OP_ST, OP_STR: begin
                    bus.en_d_mem        = 1'b1;
                    bus.d_mem_addr_mode = (bus.instr == OP_STR);
                end
                OP_BAR:  bus.base_reg_ld = 1'b1;
                OP_LDI:  bus.en_acc = 1'b1;
                OP_LDAR: begin
                    bus.en_acc   = 1'b1;
                    bus.in_b_sel = B_REG;
                end
                OP_STAR: bus.en_reg_f = 1'b1;
                OP_XORR, OP_ORR, OP_ANDR, OP_ADDR, OP_SUBR: begin
                    bus.en_acc   = 1'b1;
                    bus.in_b_sel = B_REG;
                    bus.alu_out  = ALU_INSTR_WIDTH'(bus.instr - OP_LDAR);
                end
                OP_JMP:  bus.pc_ld = 1'b1;
                OP_JMPO: begin
                    bus.pc_ld    = 1'b1;
                    bus.jmp_mode = 2'b01;
                end
                OP_JZ:   bus.pc_ld = bus.z_flag;
                OP_JNZ:  bus.pc_ld = ~bus.z_flag;
                OP_CALL: begin
                    bus.pc_ld = 1'b1;
                    bus.lr_ld = 1'b1;
                end
                OP_RET: begin
                    bus.pc_ld    = link_valid;
                    bus.jmp_mode = link_valid ? 2'b10 : 2'b00;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_decoder.sv
// Randomized bench for instr_decoder: behavioural opcode-table model
// checked every cycle, plus literal spot checks.
module tb_instr_decoder;
    typedef struct packed {
        logic       pc_rst;
        logic       pc_ld;
        logic [3:0] alu;
        logic [7:0] imm;
        logic [1:0] bsel;
        logic [3:0] rsel;
        logic       en_reg_f;
        logic [7:0] addr;
        logic       mode;
        logic       en_d_mem;
        logic       en_acc;
        logic [1:0] jmode;
        logic [7:0] off;
        logic       bar_ld;
        logic [7:0] bar_data;
        logic       lr_ld;
    } outs_t;

    logic clk = 1'b0;
    logic rst;
    logic lvm;
    logic chk = 1'b0;
    int   tests = 0;
    int   fails = 0;

    instr_decoder_if bus ();

    instr_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic outs_t model(input logic [7:0] op, input logic [7:0] a,
                                    input logic z, input logic lv, input logic r);
        outs_t o;
        o = '0;
        if (r) begin
            o.pc_rst = 1'b1;
            return o;
        end
        o.imm = a; o.addr = a; o.off = a; o.bar_data = a; o.rsel = a[3:0];
        if (op == 8'h01) o.pc_rst = 1'b1;
        if (op == 8'h02 || op == 8'h04) begin
            o.en_acc = 1'b1; o.bsel = 2'b10; o.mode = (op == 8'h04);
        end
        if (op == 8'h03 || op == 8'h05) begin
            o.en_d_mem = 1'b1; o.mode = (op == 8'h05);
        end
        if (op == 8'h06) o.bar_ld = 1'b1;
        if (op == 8'h09) o.en_acc = 1'b1;
        if (op >= 8'h0A && op <= 8'h0F) begin
            o.en_acc = 1'b1; o.bsel = 2'b01; o.alu = 4'(op - 8'h0A);
        end
        if (op == 8'h14) o.en_reg_f = 1'b1;
        if (op == 8'h07 || op == 8'h10) o.pc_ld = 1'b1;
        if (op == 8'h08) begin o.pc_ld = 1'b1; o.jmode = 2'b01; end
        if (op == 8'h12) o.pc_ld = z;
        if (op == 8'h13) o.pc_ld = !z;
        if (op == 8'h10) o.lr_ld = 1'b1;
        if (op == 8'h11 && lv) begin o.pc_ld = 1'b1; o.jmode = 2'b10; end
        return o;
    endfunction

    outs_t got, exp_o;
    assign got = '{bus.pc_rst, bus.pc_ld, bus.alu_out, bus.imm, bus.in_b_sel,
                   bus.reg_f_sel, bus.en_reg_f, bus.d_mem_addr, bus.d_mem_addr_mode,
                   bus.en_d_mem, bus.en_acc, bus.jmp_mode, bus.base_reg_offset,
                   bus.base_reg_ld, bus.base_reg_data, bus.lr_ld};

    always @(negedge clk) begin
        if (chk) begin
            exp_o = model(bus.instr, bus.arg, bus.z_flag, lvm, rst);
            tests++;
            if (got !== exp_o) begin
                fails++;
                $display("FAIL model t=%0t instr=%h arg=%h z=%b rst=%b got=%h want=%h",
                         $time, bus.instr, bus.arg, bus.z_flag, rst, got, exp_o);
            end
        end
    end

    task automatic pin(input string n, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got=%h want=%h", n, act, req);
        end
    endtask

    task automatic apply(input logic [7:0] i, input logic [7:0] a,
                         input logic z, input logic r);
        rst = r;
        bus.instr = i;
        bus.arg = a;
        bus.z_flag = z;
        if (r) lvm = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) begin
            if (bus.instr == 8'h10) lvm = 1'b1;
            else if (bus.instr == 8'h11) lvm = 1'b0;
        end
        #1;
    endtask

    initial begin
        logic [7:0] op;
        logic       r;
        lvm = 1'b0;
        rst = 1'b1;
        bus.instr = 8'h0E; bus.arg = 8'h05; bus.z_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk = 1'b1;
        apply(8'h0E, 8'h05, 1'b0, 1'b1);
        pin("rst_pc_rst", 8'(bus.pc_rst), 8'h1);
        pin("rst_en_acc", 8'(bus.en_acc), 8'h0);
        pin("rst_imm", bus.imm, 8'h00);
        step();
        apply(8'h11, 8'h33, 1'b0, 1'b0);
        pin("ret_after_rst_pc_ld", 8'(bus.pc_ld), 8'h0);
        step();
        apply(8'h02, 8'h09, 1'b0, 1'b0);
        pin("ld_en_acc", 8'(bus.en_acc), 8'h1);
        pin("ld_bsel", 8'(bus.in_b_sel), 8'h2);
        pin("ld_addr", bus.d_mem_addr, 8'h09);
        pin("ld_mode", 8'(bus.d_mem_addr_mode), 8'h0);
        step();
        apply(8'h05, 8'h07, 1'b0, 1'b0);
        pin("str_en_d_mem", 8'(bus.en_d_mem), 8'h1);
        pin("str_mode", 8'(bus.d_mem_addr_mode), 8'h1);
        pin("str_off", bus.base_reg_offset, 8'h07);
        step();
        apply(8'h09, 8'h0F, 1'b0, 1'b0);
        pin("ldi_imm", bus.imm, 8'h0F);
        pin("ldi_bsel", 8'(bus.in_b_sel), 8'h0);
        pin("ldi_en_acc", 8'(bus.en_acc), 8'h1);
        step();
        apply(8'h0F, 8'h06, 1'b0, 1'b0);
        pin("subr_alu", 8'(bus.alu_out), 8'h5);
        pin("subr_rsel", 8'(bus.reg_f_sel), 8'h6);
        pin("subr_bsel", 8'(bus.in_b_sel), 8'h1);
        step();
        apply(8'h06, 8'hA1, 1'b0, 1'b0);
        pin("bar_ld", 8'(bus.base_reg_ld), 8'h1);
        pin("bar_data", bus.base_reg_data, 8'hA1);
        step();
        apply(8'h08, 8'h0C, 1'b0, 1'b0);
        pin("jmpo_pc_ld", 8'(bus.pc_ld), 8'h1);
        pin("jmpo_mode", 8'(bus.jmp_mode), 8'h1);
        pin("jmpo_imm", bus.imm, 8'h0C);
        step();
        apply(8'h12, 8'h20, 1'b0, 1'b0);
        pin("jz_z0", 8'(bus.pc_ld), 8'h0);
        step();
        apply(8'h12, 8'h20, 1'b1, 1'b0);
        pin("jz_z1", 8'(bus.pc_ld), 8'h1);
        step();
        apply(8'h13, 8'h20, 1'b0, 1'b0);
        pin("jnz_z0", 8'(bus.pc_ld), 8'h1);
        step();
        apply(8'h13, 8'h20, 1'b1, 1'b0);
        pin("jnz_z1", 8'(bus.pc_ld), 8'h0);
        step();
        apply(8'h10, 8'h06, 1'b0, 1'b0);
        pin("call_lr_ld", 8'(bus.lr_ld), 8'h1);
        pin("call_pc_ld", 8'(bus.pc_ld), 8'h1);
        step();
        apply(8'h00, 8'h00, 1'b0, 1'b0);
        step();
        apply(8'h10, 8'h06, 1'b0, 1'b0);
        step();
        apply(8'h11, 8'h00, 1'b0, 1'b0);
        pin("ret_pc_ld", 8'(bus.pc_ld), 8'h1);
        pin("ret_mode", 8'(bus.jmp_mode), 8'h2);
        step();
        apply(8'h11, 8'h00, 1'b0, 1'b0);
        pin("ret2_pc_ld", 8'(bus.pc_ld), 8'h0);
        pin("ret2_mode", 8'(bus.jmp_mode), 8'h0);
        step();
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0:       op = 8'h10;
                1:       op = 8'h11;
                2:       op = 8'($urandom_range(0, 255));
                default: op = 8'($urandom_range(0, 21));
            endcase
            r = ($urandom_range(0, 59) == 0);
            apply(op, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), r);
            step();
        end
        apply(8'h00, 8'h00, 1'b0, 1'b0);
        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
